// File: rtl/dsp_mult_arbiter.sv
// Round-robin arbiter sharing one input-registered DSP38 multiplier, with a credit-managed, ID-tagged response FIFO.
// Optional perf counters (perf_busy/perf_stall) are enabled by defining DSP_MULT_ARBITER_PERF_CNT_EN.
module dsp_mult_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MULT_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned ID_W         = 2
) (
  input  logic                    clk,
  input  logic                    lreset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*20-1:0]   req_a,
  input  logic [NUM_REQ*18-1:0]   req_b,
  input  logic [NUM_REQ-1:0]      req_unsigned_a,
  input  logic [NUM_REQ-1:0]      req_unsigned_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [37:0]             rsp_z,
`ifdef DSP_MULT_ARBITER_PERF_CNT_EN
  output logic [31:0]             perf_busy,
  output logic [31:0]             perf_stall,
`endif
  output logic [19:0]             dsp_a,
  output logic [17:0]             dsp_b,
  output logic                    dsp_unsigned_a,
  output logic                    dsp_unsigned_b,
  output logic [2:0]              dsp_feedback,
  output logic                    dsp_reset,
  input  logic [37:0]             dsp_z
);

  localparam int unsigned A_W   = 20;
  localparam int unsigned B_W   = 18;
  localparam int unsigned Z_W   = 38;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IDX_W = ID_W + 1;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [Z_W-1:0]  z;
  } rsp_t;

  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]        out_q, out_d;
  logic [MULT_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [ID_W-1:0]         tag_id_q [MULT_LATENCY];
  logic [ID_W-1:0]         tag_id_d [MULT_LATENCY];
  rsp_t                    mem_q [FIFO_DEPTH];
  rsp_t                    mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    rsp_valid_q;
  rsp_t                    head_q, head_d;

  logic                    found_c, issue_ok_c, xfer_c, push_c, pop_c;
  logic [ID_W-1:0]         win_c;
  logic [IDX_W-1:0]        idx_c;

  assign pop_c  = rsp_valid_q & rsp_ready;
  assign push_c = tag_vld_q[MULT_LATENCY-1];

  // Credit check: the FIFO must be able to absorb every product already in flight.
  assign issue_ok_c = lreset &&
                      ((out_q < CNT_W'(FIFO_DEPTH)) ||
                       ((out_q == CNT_W'(FIFO_DEPTH)) && pop_c));
  assign xfer_c     = found_c & issue_ok_c;

  // Round-robin search starting at the pointer.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    idx_c   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx_c = IDX_W'(ptr_q) + IDX_W'(i);
      if (idx_c >= IDX_W'(NUM_REQ)) idx_c = idx_c - IDX_W'(NUM_REQ);
      if (!found_c && req_valid[idx_c[ID_W-1:0]]) begin
        found_c = 1'b1;
        win_c   = idx_c[ID_W-1:0];
      end
    end
  end

  // Grant and operand mux toward the DSP input register.
  always_comb begin
    req_ready      = '0;
    dsp_a          = '0;
    dsp_b          = '0;
    dsp_unsigned_a = 1'b0;
    dsp_unsigned_b = 1'b0;
    if (xfer_c) begin
      req_ready[win_c] = 1'b1;
      dsp_a            = req_a[A_W*32'(win_c) +: A_W];
      dsp_b            = req_b[B_W*32'(win_c) +: B_W];
      dsp_unsigned_a   = req_unsigned_a[win_c];
      dsp_unsigned_b   = req_unsigned_b[win_c];
    end
  end

  assign dsp_feedback = 3'b000;
  assign dsp_reset    = ~lreset;

  // Pointer, outstanding credit and tag pipeline next state.
  always_comb begin
    ptr_d     = ptr_q;
    out_d     = out_q + CNT_W'(xfer_c) - CNT_W'(pop_c);
    tag_vld_d = '0;
    tag_id_d  = tag_id_q;
    if (xfer_c) begin
      ptr_d = (32'(win_c) == NUM_REQ - 1) ? '0 : win_c + ID_W'(1);
    end
    tag_vld_d[0] = xfer_c;
    tag_id_d[0]  = win_c;
    for (int unsigned k = 1; k < MULT_LATENCY; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
  end

  // Response FIFO; head register is loaded from the post-update array so outputs stay registered.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    if (push_c) begin
      mem_d[wr_q] = '{id: tag_id_q[MULT_LATENCY-1], z: dsp_z};
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop_c) rd_d = rd_q + PTR_W'(1);
    head_d = mem_d[rd_d];
  end

  always_ff @(posedge clk or negedge lreset) begin
    if (!lreset) begin
      ptr_q       <= '0;
      out_q       <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '{default: '0};
      mem_q       <= '{default: '0};
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      head_q      <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_q       <= out_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      mem_q       <= mem_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= (cnt_d != '0);
      head_q      <= head_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = head_q.id;
  assign rsp_z     = head_q.z;

`ifdef DSP_MULT_ARBITER_PERF_CNT_EN
  logic [31:0] busy_q, busy_d, stall_q, stall_d;

  // Saturating activity counters.
  always_comb begin
    busy_d  = busy_q;
    stall_d = stall_q;
    if (xfer_c && (busy_q != 32'hFFFF_FFFF)) busy_d = busy_q + 32'd1;
    if ((|req_valid) && !xfer_c && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge lreset) begin
    if (!lreset) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign perf_busy  = busy_q;
  assign perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_dsp_mult_arbiter.sv
// Directed bench for dsp_mult_arbiter with a behavioural input-registered DSP38 multiplier model.
// Perf counter checks are compiled in when DSP_MULT_ARBITER_PERF_CNT_EN is defined.
module tb_dsp_mult_arbiter;

  logic        clk;
  logic        lreset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [79:0] req_a;
  logic [71:0] req_b;
  logic [3:0]  req_unsigned_a;
  logic [3:0]  req_unsigned_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [37:0] rsp_z;
  logic [19:0] dsp_a;
  logic [17:0] dsp_b;
  logic        dsp_unsigned_a;
  logic        dsp_unsigned_b;
  logic [2:0]  dsp_feedback;
  logic        dsp_reset;
  logic [37:0] dsp_z;
`ifdef DSP_MULT_ARBITER_PERF_CNT_EN
  logic [31:0] perf_busy;
  logic [31:0] perf_stall;
`endif

  int errors = 0;
  int checks = 0;

  dsp_mult_arbiter dut (
    .clk            (clk),
    .lreset         (lreset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_unsigned_a (req_unsigned_a),
    .req_unsigned_b (req_unsigned_b),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_id         (rsp_id),
    .rsp_z          (rsp_z),
`ifdef DSP_MULT_ARBITER_PERF_CNT_EN
    .perf_busy      (perf_busy),
    .perf_stall     (perf_stall),
`endif
    .dsp_a          (dsp_a),
    .dsp_b          (dsp_b),
    .dsp_unsigned_a (dsp_unsigned_a),
    .dsp_unsigned_b (dsp_unsigned_b),
    .dsp_feedback   (dsp_feedback),
    .dsp_reset      (dsp_reset),
    .dsp_z          (dsp_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DSP38 model: registered inputs, combinational multiplier output.
  logic [19:0] a_r;
  logic [17:0] b_r;
  logic        ua_r, ub_r;
  logic [37:0] ax, bx;
  always @(posedge clk) begin
    if (dsp_reset) begin
      a_r <= '0; b_r <= '0; ua_r <= 1'b0; ub_r <= 1'b0;
    end else begin
      a_r <= dsp_a; b_r <= dsp_b; ua_r <= dsp_unsigned_a; ub_r <= dsp_unsigned_b;
    end
  end
  always_comb begin
    ax = ua_r ? {18'b0, a_r} : {{18{a_r[19]}}, a_r};
    bx = ub_r ? {20'b0, b_r} : {{20{b_r[17]}}, b_r};
  end
  assign dsp_z = ax * bx;

  task automatic set_req(input int i, input logic [19:0] a, input logic [17:0] b,
                         input logic ua, input logic ub);
    req_a[i*20 +: 20]  = a;
    req_b[i*18 +: 18]  = b;
    req_unsigned_a[i]  = ua;
    req_unsigned_b[i]  = ub;
  endtask

  task automatic test_reset();
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    checks++; if (rsp_z !== 38'd0) begin errors++; $display("FAIL reset_rsp_z: got %h want 0", rsp_z); end
    checks++; if (dsp_a !== 20'd0 || dsp_b !== 18'd0) begin errors++; $display("FAIL reset_dsp_ab: got %h/%h want 0/0", dsp_a, dsp_b); end
    checks++; if (dsp_feedback !== 3'b000) begin errors++; $display("FAIL reset_feedback: got %b want 000", dsp_feedback); end
    checks++; if (dsp_reset !== 1'b1) begin errors++; $display("FAIL reset_dsp_reset: got %b want 1", dsp_reset); end
    @(negedge clk);
    req_valid = 4'h0;
    lreset    = 1'b1;
    #1;
    checks++; if (dsp_reset !== 1'b0) begin errors++; $display("FAIL release_dsp_reset: got %b want 0", dsp_reset); end
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req(2, 20'd1000, 18'd300, 1'b1, 1'b1);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", req_ready); end
    checks++; if (dsp_a !== 20'd1000 || dsp_b !== 18'd300) begin errors++; $display("FAIL single_dsp_ab: got %0d/%0d want 1000/300", dsp_a, dsp_b); end
    checks++; if (dsp_unsigned_a !== 1'b1 || dsp_unsigned_b !== 1'b1) begin errors++; $display("FAIL single_flags: got %b%b want 11", dsp_unsigned_a, dsp_unsigned_b); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", rsp_valid); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d want 2", rsp_id); end
    checks++; if (rsp_z !== 38'd300000) begin errors++; $display("FAIL single_z: got %0d want 300000", rsp_z); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_popped: got %b want 0", rsp_valid); end
  endtask

  task automatic test_signed();
    @(negedge clk);
    set_req(3, 20'hFFFFD, 18'd7, 1'b0, 1'b0);
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL signed_grant: got %b want 1000", req_ready); end
    checks++; if (dsp_unsigned_a !== 1'b0 || dsp_unsigned_b !== 1'b0) begin errors++; $display("FAIL signed_flags: got %b%b want 00", dsp_unsigned_a, dsp_unsigned_b); end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin errors++; $display("FAIL signed_rsp: got v=%b id=%0d want v=1 id=3", rsp_valid, rsp_id); end
    checks++; if (rsp_z !== 38'h3F_FFFF_FFEB) begin errors++; $display("FAIL signed_z: got %h want 3fffffffeb", rsp_z); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_gnt [5];
    logic [1:0]  exp_id  [5];
    logic [37:0] exp_z   [5];
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_z   = '{38'd10, 38'd18, 38'd28, 38'd40, 38'd10};
    for (int i = 0; i < 4; i++) set_req(i, 20'(i + 5), 18'(i + 2), 1'b1, 1'b1);
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req_valid = (k < 5) ? 4'hF : 4'h0;
      #1;
      if (k < 5) begin
        checks++; if (req_ready !== exp_gnt[k]) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_gnt[k]); end
      end
      if (k >= 2 && k < 7) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== exp_id[k-2] || rsp_z !== exp_z[k-2]) begin
          errors++;
          $display("FAIL rr_rsp[%0d]: got v=%b id=%0d z=%0d want v=1 id=%0d z=%0d", k, rsp_valid, rsp_id, rsp_z, exp_id[k-2], exp_z[k-2]);
        end
      end
      if (k == 7) begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_drained: got %b want 0", rsp_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]  exp_gnt [4];
    logic [1:0]  dr_id   [4];
    logic [37:0] dr_z    [4];
    exp_gnt = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    dr_id   = '{2'd2, 2'd3, 2'd0, 2'd1};
    dr_z    = '{38'd28, 38'd40, 38'd10, 38'd18};
    rsp_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      req_valid = 4'hF;
      #1;
      if (k < 4) begin
        checks++; if (req_ready !== exp_gnt[k]) begin errors++; $display("FAIL bp_grant[%0d]: got %b want %b", k, req_ready, exp_gnt[k]); end
      end else begin
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_blocked[%0d]: got %b want 0000", k, req_ready); end
      end
    end
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin errors++; $display("FAIL bp_head: got v=%b id=%0d want v=1 id=1", rsp_valid, rsp_id); end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_pop_issue: got %b want 0010", req_ready); end
    checks++; if (rsp_z !== 38'd18) begin errors++; $display("FAIL bp_pop_z: got %0d want 18", rsp_z); end
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_one_only: got %b want 0000", req_ready); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL bp_next_head: got %0d want 2", rsp_id); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid = 4'h0;
      rsp_ready = 1'b1;
      #1;
      if (k < 4) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== dr_id[k] || rsp_z !== dr_z[k]) begin
          errors++;
          $display("FAIL bp_drain[%0d]: got v=%b id=%0d z=%0d want v=1 id=%0d z=%0d", k, rsp_valid, rsp_id, rsp_z, dr_id[k], dr_z[k]);
        end
      end else begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", rsp_valid); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL mid_grant: got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = 4'hF;
    lreset    = 1'b0;
    #1;
    checks++; if (dsp_reset !== 1'b1) begin errors++; $display("FAIL mid_dsp_reset: got %b want 1", dsp_reset); end
    checks++; if (req_ready !== 4'b0000 || dsp_a !== 20'd0) begin errors++; $display("FAIL mid_no_grant: got %b a=%0d want 0000 a=0", req_ready, dsp_a); end
    @(negedge clk);
    req_valid = 4'h0;
    lreset    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_rsp[%0d]: got %b want 0", k, rsp_valid); end
      @(negedge clk);
    end
  endtask

`ifdef DSP_MULT_ARBITER_PERF_CNT_EN
  task automatic test_perf();
    set_req(0, 20'd2, 18'd3, 1'b1, 1'b1);
    rsp_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      req_valid = 4'b0001;
      @(negedge clk);
    end
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      req_valid = 4'b0001;
      @(negedge clk);
    end
    req_valid = 4'h0;
    #1;
    checks++; if (perf_busy !== 32'd10) begin errors++; $display("FAIL perf_busy: got %0d want 10", perf_busy); end
    checks++; if (perf_stall !== 32'd3) begin errors++; $display("FAIL perf_stall: got %0d want 3", perf_stall); end
  endtask
`endif

  initial begin
    lreset         = 1'b0;
    req_valid      = '0;
    req_a          = '0;
    req_b          = '0;
    req_unsigned_a = '0;
    req_unsigned_b = '0;
    rsp_ready      = 1'b1;
    test_reset();
    test_single();
    test_signed();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
`ifdef DSP_MULT_ARBITER_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dsp_mult_arbiter.md
Name: dsp_mult_arbiter

Overview:
- Shares one DSP38 multiplier between NUM_REQ requesters. The DSP38 is configured with DSP_MODE "MULTIPY", INPUT_REG_EN "TRUE" and OUTPUT_REG_EN "FALSE".
- Round-robin arbitration; issues one product per cycle; tracks each in-flight product by requester ID.
- Buffers results in an ID-tagged response FIFO under credit control, so backpressure never drops a product.
- Sits between accelerator clients and the DSP38 instance; drives its A/B/UNSIGNED/FEEDBACK/RESET pins and reads its Z output.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- MULT_LATENCY, 1, clock edges from DSP input capture to valid Z (1 for input-registered mode)
- FIFO_DEPTH, 4, response FIFO entries (power of 2, at least MULT_LATENCY+1)
- ID_W, 2, requester ID width, equal to clog2(NUM_REQ)

Ports:
- clk  in  1  single clock, rising edge
- lreset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant (one-hot or zero)
- req_a  in  NUM_REQ*20  packed multiplicands
- req_b  in  NUM_REQ*18  packed multipliers
- req_unsigned_a  in  NUM_REQ  per-requester A signedness
- req_unsigned_b  in  NUM_REQ  per-requester B signedness
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_id  out  ID_W  requester that owns rsp_z
- rsp_z  out  38  product
- dsp_a  out  20  to DSP38 A
- dsp_b  out  18  to DSP38 B
- dsp_unsigned_a  out  1  to DSP38 UNSIGNED_A
- dsp_unsigned_b  out  1  to DSP38 UNSIGNED_B
- dsp_feedback  out  3  to DSP38 FEEDBACK; constant 3'b000
- dsp_reset  out  1  to DSP38 RESET; active-high, equal to ~lreset
- dsp_z  in  38  from DSP38 Z

Behaviour:
- Reset (lreset=0, asynchronous):
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_z=0.
  - Round-robin pointer=0; tag pipeline cleared; FIFO empty; outstanding=0.
  - dsp_a/dsp_b/dsp_unsigned_* driven 0.
- Outstanding count = tags in flight + FIFO occupancy. Range 0..FIFO_DEPTH.
- Issue condition: outstanding < FIFO_DEPTH, or outstanding == FIFO_DEPTH with a FIFO pop in the same cycle.
- Arbitration (combinational, each cycle issue is allowed):
  - Grant the first req_valid at or after the pointer, cyclically.
  - req_ready is one-hot to the winner. A transfer occurs when req_valid&req_ready.
  - On a transfer, the pointer moves to winner+1, wrapping at NUM_REQ-1 to 0.
  - No transfer leaves the pointer unchanged.
- Issue datapath:
  - dsp_a/dsp_b/dsp_unsigned_* are combinationally muxed from the winner; 0 when there is no grant.
  - The DSP input register captures them at the edge ending the issue cycle.
- Tag pipeline:
  - MULT_LATENCY stages of {valid, id}; stage 0 is loaded on transfer.
  - When the last stage is valid, dsp_z is sampled in the same cycle and pushed into the FIFO as {id, z}.
  - For MULT_LATENCY=1, a product issued in cycle t is pushed into the FIFO at the end of cycle t+1.
  - rsp_valid rises in cycle t+2 at the earliest.
- FIFO:
  - Registered outputs. rsp_valid = not empty.
  - Pop on rsp_valid&rsp_ready. Push and pop in the same cycle are both honoured.
  - Ordering is strictly issue order.
- Credit: the issue condition guarantees push never hits a full FIFO. Overflow is impossible by construction.
- Width: the product is taken from dsp_z unmodified. Signedness is applied by the DSP per UNSIGNED flags; the arbiter performs no arithmetic.
- Simultaneous events: a grant and a pop in the same cycle at full credit issue; a push and a pop on a full FIFO are both legal.
- Reset mid-operation: all in-flight tags and FIFO contents are discarded. No response is emitted after reset release until a new issue.
- Requester rules:
  - A requester must hold req_a/req_b/flags stable while req_valid=1 and req_ready=0.
  - Deasserting req_valid before grant is permitted.

Optional Feature:
- Macro: DSP_MULT_ARBITER_PERF_CNT_EN
- With the macro defined, two extra ports are added:
  - perf_busy (out, 32): increments each transfer cycle.
  - perf_stall (out, 32): increments each cycle with any req_valid high and no transfer.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Without the macro, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Single request: requester 2 sends a=20'd1000, b=18'd300, unsigned both. req_ready[2]=1 in the same cycle. rsp_valid is 1 two cycles later with rsp_id=2 and rsp_z=38'd300000.
- Signed: a=-3 (20'hFFFFD), b=7, unsigned_a=0, unsigned_b=0 -> rsp_z=38'h3F_FFFF_FFEB (-21).
- Round-robin: all 4 requesters hold req_valid continuously with rsp_ready=1. Grants go 0,1,2,3,0 on consecutive cycles and rsp_id follows the same order.
- Backpressure: rsp_ready=0 with 4 requesters active. Exactly FIFO_DEPTH=4 transfers occur, then req_ready stays 0. Raising rsp_ready for 1 cycle pops one entry and allows exactly one new issue. No product is lost.
- Reset mid-flight: assert lreset=0 one cycle after an issue. rsp_valid stays 0 after release, and dsp_reset=1 while lreset=0.
- With DSP_MULT_ARBITER_PERF_CNT_EN: 10 transfers plus 3 blocked cycles -> perf_busy=10 and perf_stall=3.
